// File: rtl/core_seq_pkg.sv
// Shared types and constants for the RV32 multi-cycle sequencer.
// State encoding, RV32 major opcodes and fault cause codes.
package core_seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    function automatic logic is_legal_op(input logic [6:0] op);
        logic ok;
        case (op)
            OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/core_perf_counters.sv
// Cycle and retired-instruction counters for the sequencer.
// Only instantiated when CORE_SEQ_PERF_EN is defined.
module core_perf_counters
    import core_seq_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            cycle_count <= cycle_count + CNT_W'(1);
            if (retire)
                instret_count <= instret_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for RV32.
// Optional perf counters enabled by defining CORE_SEQ_PERF_EN.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             reg_write_enable_dec,
    input  logic             dmem_write_enable_dec,
    input  logic             dmem_read_enable_dec,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             ir_write_enable,
    output logic             pc_write_enable,
    output logic             reg_write_enable,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [2:0]       state_dbg,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        cause_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FETCH;
            wait_cnt <= '0;
            cause_q  <= CAUSE_NONE;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        state <= ST_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= ST_FAULT;
                        cause_q <= CAUSE_IMEM;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (opcode == OP_SYSTEM) begin
                        state <= ST_HALT;
                    end else if (!is_legal_op(opcode)) begin
                        state   <= ST_FAULT;
                        cause_q <= CAUSE_ILLEGAL;
                    end else begin
                        state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (dmem_read_enable_dec || dmem_write_enable_dec) begin
                        state    <= ST_MEM;
                        wait_cnt <= '0;
                    end else begin
                        state <= ST_WRITEBACK;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        state <= ST_WRITEBACK;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= ST_FAULT;
                        cause_q <= CAUSE_DMEM;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_WRITEBACK: begin
                    state    <= ST_FETCH;
                    wait_cnt <= '0;
                end
                ST_HALT, ST_FAULT: state <= state;
                default: state <= ST_FAULT;
            endcase
        end
    end

    // Requests and strobes are masked combinationally while reset is held.
    logic run;
    assign run = !rst;

    assign imem_req         = run && (state == ST_FETCH);
    assign ir_write_enable  = imem_req && imem_ready;
    assign dmem_req         = run && (state == ST_MEM);
    assign dmem_we          = dmem_req && dmem_write_enable_dec;
    assign pc_write_enable  = run && (state == ST_WRITEBACK);
    assign reg_write_enable = pc_write_enable && reg_write_enable_dec;
    assign halted           = (state == ST_HALT);
    assign fault            = (state == ST_FAULT);
    assign fault_cause      = cause_q;
    assign state_dbg        = state;

`ifdef CORE_SEQ_PERF_EN
    core_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst          (rst),
        .retire       (pc_write_enable),
        .cycle_count  (cycle_count),
        .instret_count(instret_count)
    );
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer.
// Counter expectations follow CORE_SEQ_PERF_EN.
module tb_core_sequencer;
    import core_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = '0;
    logic        reg_write_enable_dec = 1'b0;
    logic        dmem_write_enable_dec = 1'b0;
    logic        dmem_read_enable_dec = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, dmem_req, dmem_we;
    logic        ir_write_enable, pc_write_enable, reg_write_enable;
    logic        halted, fault;
    logic [1:0]  fault_cause;
    logic [2:0]  state_dbg;
    logic [31:0] cycle_count, instret_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    core_sequencer #(
        .MEM_TIMEOUT(16),
        .CNT_W(32)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .opcode               (opcode),
        .reg_write_enable_dec (reg_write_enable_dec),
        .dmem_write_enable_dec(dmem_write_enable_dec),
        .dmem_read_enable_dec (dmem_read_enable_dec),
        .imem_req             (imem_req),
        .imem_ready           (imem_ready),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_ready           (dmem_ready),
        .ir_write_enable      (ir_write_enable),
        .pc_write_enable      (pc_write_enable),
        .reg_write_enable     (reg_write_enable),
        .halted               (halted),
        .fault                (fault),
        .fault_cause          (fault_cause),
        .state_dbg            (state_dbg),
        .cycle_count          (cycle_count),
        .instret_count        (instret_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic run_instr(input string tag, input logic [6:0] op,
                             input logic rw, input logic wr, input logic rd,
                             input int mem_wait, input int exp_len,
                             input logic [31:0] exp_seq);
        logic [31:0] seq;
        int pc_n, pc_at, reg_n, req_n, we_n, ir_n;
        int exp_req;
        seq = '0;
        pc_n = 0; pc_at = -1; reg_n = 0; req_n = 0; we_n = 0; ir_n = 0;
        opcode = op;
        reg_write_enable_dec = rw;
        dmem_write_enable_dec = wr;
        dmem_read_enable_dec = rd;
        imem_ready = 1'b1;
        for (int i = 0; i < exp_len; i++) begin
            dmem_ready = (i == 3 + mem_wait);
            #1;
            seq = (seq << 4) | 32'(state_dbg);
            if (pc_write_enable) begin
                pc_n++;
                pc_at = i;
            end
            if (reg_write_enable) reg_n++;
            if (ir_write_enable) ir_n++;
            if (dmem_req) begin
                req_n++;
                if (dmem_we) we_n++;
            end
            cyc();
        end
        dmem_ready = 1'b0;
        #1;
        exp_req = (rd || wr) ? mem_wait + 1 : 0;
        check({tag, "/seq"}, seq, exp_seq);
        check({tag, "/len"}, 32'(state_dbg), 32'(ST_FETCH));
        check({tag, "/pc_n"}, 32'(pc_n), 1);
        check({tag, "/pc_at"}, 32'(pc_at), 32'(exp_len - 1));
        check({tag, "/reg_n"}, 32'(reg_n), 32'(rw));
        check({tag, "/ir_n"}, 32'(ir_n), 1);
        check({tag, "/req_n"}, 32'(req_n), 32'(exp_req));
        check({tag, "/we_n"}, 32'(we_n), wr ? 32'(exp_req) : 0);
    endtask

    initial begin
        int n;
        logic [31:0] exp_cyc, exp_ret;

        #1;
        check("rst_imem_req", 32'(imem_req), 0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("rst_state", 32'(state_dbg), 0);
        check("rst_imem_req_rel", 32'(imem_req), 1);
        check("rst_strobes", {29'd0, ir_write_enable, pc_write_enable,
                              reg_write_enable}, 0);
        check("rst_dmem_req", 32'(dmem_req), 0);
        check("rst_cause", 32'(fault_cause), 0);
        check("rst_flags", {30'd0, halted, fault}, 0);
        check("rst_cycles", cycle_count, 0);
        check("rst_instret", instret_count, 0);

        run_instr("add", OP_REG, 1'b1, 1'b0, 1'b0, 0, 4, 32'h0124);
`ifdef CORE_SEQ_PERF_EN
        exp_cyc = 32'd4;
        exp_ret = 32'd1;
`else
        exp_cyc = 32'd0;
        exp_ret = 32'd0;
`endif
        check("add_cycles", cycle_count, exp_cyc);
        check("add_instret", instret_count, exp_ret);

        run_instr("lw", OP_LOAD, 1'b1, 1'b0, 1'b1, 3, 8, 32'h01233334);
        run_instr("sw", OP_STORE, 1'b0, 1'b1, 1'b0, 0, 5, 32'h01234);
        run_instr("rdwr", OP_STORE, 1'b0, 1'b1, 1'b1, 1, 6, 32'h012334);
        run_instr("beq", OP_BRANCH, 1'b0, 1'b0, 1'b0, 0, 4, 32'h0124);

        imem_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (imem_req && state_dbg == 3'd0) n++;
            cyc();
        end
        #1;
        check("ito_wait_cycles", 32'(n), 16);
        check("ito_fault", 32'(fault), 1);
        check("ito_state", 32'(state_dbg), 32'(ST_FAULT));
        check("ito_cause", 32'(fault_cause), 32'(CAUSE_IMEM));
        check("ito_imem_req", 32'(imem_req), 0);
        imem_ready = 1'b1;
        cyc();
        check("ito_absorb", {30'd0, fault, ir_write_enable}, 32'h2);

        do_reset();
        for (int i = 0; i < 15; i++) cyc();
        imem_ready = 1'b1;
        opcode = 7'b0000000;
        #1;
        check("i15_ir_we", 32'(ir_write_enable), 1);
        cyc();
        check("i15_decode", 32'(state_dbg), 32'(ST_DECODE));
        check("i15_no_fault", 32'(fault), 0);
        imem_ready = 1'b0;
        cyc();
        check("ill_state", 32'(state_dbg), 32'(ST_FAULT));
        check("ill_cause", 32'(fault_cause), 32'(CAUSE_ILLEGAL));
        check("ill_halted", 32'(halted), 0);

        do_reset();
        opcode = OP_SYSTEM;
        imem_ready = 1'b1;
        cyc();
        cyc();
        imem_ready = 1'b0;
        #1;
        check("halt_state", 32'(state_dbg), 32'(ST_HALT));
        check("halt_flag", 32'(halted), 1);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'b1;
            #1;
            if (pc_write_enable || imem_req || dmem_req || ir_write_enable) n++;
            cyc();
        end
        check("halt_quiet", 32'(n), 0);
        check("halt_cause", {29'd0, fault, fault_cause}, 0);

        do_reset();
        opcode = OP_LOAD;
        reg_write_enable_dec = 1'b1;
        dmem_read_enable_dec = 1'b1;
        dmem_write_enable_dec = 1'b0;
        imem_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        #1;
        check("rmem_in_mem", {30'd0, state_dbg == 3'd3, dmem_req}, 32'h3);
        rst = 1'b1;
        #1;
        check("rmem_forced", 32'(dmem_req), 0);
        cyc();
        rst = 1'b0;
        #1;
        check("rmem_state", 32'(state_dbg), 32'(ST_FETCH));
        check("rmem_dmem_req", 32'(dmem_req), 0);

        cyc();
        cyc();
        cyc();
        imem_ready = 1'b0;
        #1;
        check("dto_in_mem", 32'(state_dbg), 32'(ST_MEM));
        for (int i = 0; i < 16; i++) cyc();
        check("dto_state", 32'(state_dbg), 32'(ST_FAULT));
        check("dto_cause", 32'(fault_cause), 32'(CAUSE_DMEM));
        check("dto_dmem_req", 32'(dmem_req), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
